// File: rtl/dm_pkg.sv
// Shared types and defaults for the demodulator receive-frame controller.
package dm_pkg;

  typedef enum logic [1:0] {IDLE, HUNT, RECV, HOLD} dm_frame_state_t;

  localparam logic [7:0] DM_SYNC_WORD_DEF  = 8'hA5;
  localparam int         DM_DATA_BITS_DEF  = 16;
  localparam int         DM_TIMEOUT_DEF    = 255;

endpackage

// File: rtl/dm_sync_det.sv
// Sync-word hunter: shifts qualified bits MSB first and flags the bit that completes the pattern.
module dm_sync_det
  import dm_pkg::*;
#(
  parameter int                   SYNC_BITS = 8,
  parameter logic [SYNC_BITS-1:0] SYNC_WORD = DM_SYNC_WORD_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_bit_valid,
  input  logic i_bit_in,
  output logic o_sync_hit
);

  logic [SYNC_BITS-1:0] r_sr;
  logic [SYNC_BITS-1:0] w_sr_next;

  assign w_sr_next = {r_sr[SYNC_BITS-2:0], i_bit_in};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr <= '0;
    end else if (i_clr) begin
      r_sr <= '0;
    end else if (i_bit_valid) begin
      r_sr <= w_sr_next;
    end
  end

  // Hit is combinational so the controller can enter RECV before the very next bit.
  assign o_sync_hit = i_bit_valid && !i_clr && (w_sr_next == SYNC_WORD);

endmodule

// File: rtl/dm_frame_ctrl.sv
// Receive-frame controller after the FSK demodulator: sync hunt, frame capture, handshake, supervision.
// Optional even-parity bit per frame is enabled by defining DM_FRAME_PARITY_EN.
module dm_frame_ctrl
  import dm_pkg::*;
#(
  parameter int                   DATA_BITS   = DM_DATA_BITS_DEF,
  parameter int                   SYNC_BITS   = 8,
  parameter logic [SYNC_BITS-1:0] SYNC_WORD   = DM_SYNC_WORD_DEF,
  parameter int                   TIMEOUT_CYC = DM_TIMEOUT_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic                 i_bit_valid,
  input  logic                 i_bit_in,
  input  logic                 i_frame_ready,
  input  logic                 i_err_clr,
  output logic [DATA_BITS-1:0] o_frame_data,
  output logic                 o_frame_valid,
  output logic                 o_frame_err,
  output logic                 o_sync_lock,
  output logic                 o_dm_clr,
  output logic                 o_timeout_err,
  output logic                 o_overrun_err
);

`ifdef DM_FRAME_PARITY_EN
  localparam int FRAME_LEN = DATA_BITS + 1;
`else
  localparam int FRAME_LEN = DATA_BITS;
`endif
  localparam int SR_W = FRAME_LEN - 1;
  localparam int CNT_W = $clog2(DATA_BITS + 2);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  dm_frame_state_t r_state;
  dm_frame_state_t w_state_next;

  logic [SR_W-1:0]      r_data_sr;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [TO_W-1:0]      r_to_cnt;
  logic [DATA_BITS-1:0] r_frame_data;
  logic                 r_frame_valid;
  logic                 r_sync_lock;
  logic                 r_dm_clr;
  logic                 r_timeout_err;
  logic                 r_overrun_err;
  logic [FRAME_LEN-1:0] w_frame_full;

  logic w_sync_hit;
  logic w_shift;
  logic w_load;
  logic w_timeout;
  logic w_overrun;
  logic w_release;

  dm_sync_det #(
    .SYNC_BITS (SYNC_BITS),
    .SYNC_WORD (SYNC_WORD)
  ) u_sync_det (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (r_state != HUNT),
    .i_bit_valid (i_bit_valid),
    .i_bit_in    (i_bit_in),
    .o_sync_hit  (w_sync_hit)
  );

  assign w_frame_full = {r_data_sr, i_bit_in};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Disable overrides everything; a bit in the timeout expiry cycle is accepted instead of timing out.
  always_comb begin
    w_state_next = r_state;
    w_shift      = 1'b0;
    w_load       = 1'b0;
    w_timeout    = 1'b0;
    w_overrun    = 1'b0;
    w_release    = 1'b0;
    if (!i_enable) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: w_state_next = HUNT;
        HUNT: begin
          if (w_sync_hit) w_state_next = RECV;
        end
        RECV: begin
          if (i_bit_valid) begin
            w_shift = 1'b1;
            if (r_bit_cnt == LAST_BIT) begin
              w_load       = 1'b1;
              w_state_next = HOLD;
            end
          end else if (r_to_cnt == TO_LAST) begin
            w_timeout    = 1'b1;
            w_state_next = HUNT;
          end
        end
        HOLD: begin
          if (r_frame_valid && i_frame_ready) begin
            w_release    = 1'b1;
            w_state_next = HUNT;
          end else if (i_bit_valid) begin
            w_overrun = 1'b1;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Counters rest at zero outside RECV, which gives the reset-on-entry behaviour for free.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
      r_data_sr <= '0;
    end else begin
      if (r_state != RECV) begin
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
      if (r_state != RECV || i_bit_valid) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      if (w_shift) begin
        r_data_sr <= w_frame_full[SR_W-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
      r_sync_lock   <= 1'b0;
      r_dm_clr      <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      if (w_load) begin
        r_frame_data <= w_frame_full[FRAME_LEN-1 -: DATA_BITS];
      end
      if (!i_enable || w_release) begin
        r_frame_valid <= 1'b0;
      end else if (w_load) begin
        r_frame_valid <= 1'b1;
      end
      r_sync_lock <= (w_state_next == RECV);
      r_dm_clr    <= w_timeout;
      // Set events beat a simultaneous clear so no error is ever lost.
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (i_err_clr) begin
        r_timeout_err <= 1'b0;
      end
      if (w_overrun) begin
        r_overrun_err <= 1'b1;
      end else if (i_err_clr) begin
        r_overrun_err <= 1'b0;
      end
    end
  end

`ifdef DM_FRAME_PARITY_EN
  logic r_frame_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_err <= 1'b0;
    end else if (w_load) begin
      r_frame_err <= ^w_frame_full;
    end
  end

  assign o_frame_err = r_frame_err;
`else
  assign o_frame_err = 1'b0;
`endif

  assign o_frame_data  = r_frame_data;
  assign o_frame_valid = r_frame_valid;
  assign o_sync_lock   = r_sync_lock;
  assign o_dm_clr      = r_dm_clr;
  assign o_timeout_err = r_timeout_err;
  assign o_overrun_err = r_overrun_err;

endmodule
